// File: rtl/rf_pkg.sv
// Shared types for the multi-port register file: clear-FSM states and
// address-width derivation used by the top and the scoreboard.
package rf_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_e;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservations,
// cleared by committed writes or by the bulk-clear sweep.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_set_en,
  input  logic [AW-1:0]              i_set_addr,
  input  logic [NUM_REGS-1:0]        i_clr_vec,
  input  logic                       i_flush_en,
  input  logic [AW-1:0]              i_flush_addr,
  input  logic [NUM_RD-1:0][AW-1:0]  i_lk_addr,
  output logic [NUM_RD-1:0]          o_lk_pend
);

  logic [NUM_REGS-1:0] sb;

  // Set beats clear so a reserve landing with an older write keeps the bit.
  // Bit 0 is never touched after reset and so never reads pending.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sb <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (i_set_en && i_set_addr == AW'(r))
          sb[r] <= 1'b1;
        else if (i_clr_vec[r] || (i_flush_en && i_flush_addr == AW'(r)))
          sb[r] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lk
    assign o_lk_pend[k] = sb[i_lk_addr[k]];
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file: async reads, prioritised sync writes, optional
// write-to-read bypass, pending scoreboard and a one-register-per-cycle bulk clear.
module rf_mp
  import rf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int BYPASS_EN = 0,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*AW-1:0]     i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  input  logic [NUM_WR-1:0]        i_wen,
  input  logic [NUM_WR*AW-1:0]     i_waddr,
  input  logic [NUM_WR*DATA_W-1:0] i_wdata,
  input  logic                     i_rsv_en,
  input  logic [AW-1:0]            i_rsv_addr,
  output logic [NUM_RD-1:0]        o_pending,
  input  logic                     i_clr_req,
  output logic                     o_clr_busy,
  output logic                     o_clr_done
);

  logic [NUM_RD-1:0][AW-1:0]     raddr;
  logic [NUM_WR-1:0][AW-1:0]     waddr;
  logic [NUM_WR-1:0][DATA_W-1:0] wdata;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;
  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_WR-1:0]             wen_eff;
  logic [NUM_REGS-1:0]           wr_clr;

  clr_state_e state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          done_q, done_nxt;
  logic          clearing, last;

  assign raddr    = i_raddr;
  assign waddr    = i_waddr;
  assign wdata    = i_wdata;
  assign o_rdata  = rdata;
  assign clearing = (state == S_CLEAR);
  assign last     = (idx == AW'(NUM_REGS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      idx    <= AW'(1);
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      done_q <= done_nxt;
    end
  end

  // The sweep exits on the last index rather than wrapping back to 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: if (i_clr_req) begin
        state_nxt = S_CLEAR;
        idx_nxt   = AW'(1);
      end
      S_CLEAR: if (last) begin
        state_nxt = S_IDLE;
        idx_nxt   = AW'(1);
        done_nxt  = 1'b1;
      end else begin
        idx_nxt = idx + AW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_clr_busy = clearing;
  assign o_clr_done = done_q;

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wen
    assign wen_eff[j] = i_wen[j] && (waddr[j] != '0) && !clearing;
  end

  always_comb begin
    wr_clr = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (wen_eff[j]) wr_clr[waddr[j]] = 1'b1;
  end

  // Ascending port order: the highest-index same-address write lands last.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem <= '0;
    end else if (clearing) begin
      mem[idx] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wen_eff[j]) mem[waddr[j]] <= wdata[j];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [DATA_W-1:0] rd;
    always_comb begin
      rd = mem[raddr[k]];
      if (BYPASS_EN != 0)
        for (int j = 0; j < NUM_WR; j++)
          if (wen_eff[j] && waddr[j] == raddr[k]) rd = wdata[j];
    end
    assign rdata[k] = i_rst ? '0 : rd;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) u_sb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_set_en     (i_rsv_en && (i_rsv_addr != '0) && !clearing),
    .i_set_addr   (i_rsv_addr),
    .i_clr_vec    (wr_clr),
    .i_flush_en   (clearing),
    .i_flush_addr (idx),
    .i_lk_addr    (raddr),
    .o_lk_pend    (o_pending)
  );

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: instance A (16 regs, 2 write ports, bypass) and
// instance B (8 regs, 2 write ports, no bypass) against an array model.
module tb_rf_mp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [7:0]  a_raddr;  logic [63:0] a_rdata;  logic [1:0] a_wen;
  logic [7:0]  a_waddr;  logic [63:0] a_wdata;  logic a_rsv_en;
  logic [3:0]  a_rsv_addr; logic [1:0] a_pend;  logic a_clr_req, a_busy, a_done;

  logic [5:0]  b_raddr;  logic [63:0] b_rdata;  logic [1:0] b_wen;
  logic [5:0]  b_waddr;  logic [63:0] b_wdata;  logic b_rsv_en;
  logic [2:0]  b_rsv_addr; logic [1:0] b_pend;  logic b_clr_req, b_busy, b_done;

  rf_mp #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(2), .NUM_WR(2), .BYPASS_EN(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_raddr(a_raddr), .o_rdata(a_rdata),
    .i_wen(a_wen), .i_waddr(a_waddr), .i_wdata(a_wdata),
    .i_rsv_en(a_rsv_en), .i_rsv_addr(a_rsv_addr), .o_pending(a_pend),
    .i_clr_req(a_clr_req), .o_clr_busy(a_busy), .o_clr_done(a_done));

  rf_mp #(.DATA_W(32), .NUM_REGS(8), .NUM_RD(2), .NUM_WR(2), .BYPASS_EN(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_raddr(b_raddr), .o_rdata(b_rdata),
    .i_wen(b_wen), .i_waddr(b_waddr), .i_wdata(b_wdata),
    .i_rsv_en(b_rsv_en), .i_rsv_addr(b_rsv_addr), .o_pending(b_pend),
    .i_clr_req(b_clr_req), .o_clr_busy(b_busy), .o_clr_done(b_done));

  // Reference model: register arrays, pending flags, clear cycles remaining.
  logic [31:0] ma [16]; bit sba [16]; int a_left, a_ptr; bit a_done_exp;
  logic [31:0] mb [8];  bit sbb [8];  int b_left, b_ptr; bit b_done_exp;

  function automatic void reset_model();
    for (int i = 0; i < 16; i++) begin ma[i] = '0; sba[i] = 0; end
    for (int i = 0; i < 8; i++)  begin mb[i] = '0; sbb[i] = 0; end
    a_left = 0; a_ptr = 1; a_done_exp = 0;
    b_left = 0; b_ptr = 1; b_done_exp = 0;
  endfunction

  function automatic void model_edge();
    if (rst) begin reset_model(); return; end
    a_done_exp = 0;
    if (a_left > 0) begin
      ma[a_ptr] = '0; sba[a_ptr] = 0; a_ptr++; a_left--; a_done_exp = (a_left == 0);
    end else begin
      for (int j = 0; j < 2; j++)
        if (a_wen[j] && a_waddr[j*4+:4] != 0) begin
          ma[a_waddr[j*4+:4]] = a_wdata[j*32+:32]; sba[a_waddr[j*4+:4]] = 0;
        end
      if (a_rsv_en && a_rsv_addr != 0) sba[a_rsv_addr] = 1;
      if (a_clr_req) begin a_left = 15; a_ptr = 1; end
    end
    b_done_exp = 0;
    if (b_left > 0) begin
      mb[b_ptr] = '0; sbb[b_ptr] = 0; b_ptr++; b_left--; b_done_exp = (b_left == 0);
    end else begin
      for (int j = 0; j < 2; j++)
        if (b_wen[j] && b_waddr[j*3+:3] != 0) begin
          mb[b_waddr[j*3+:3]] = b_wdata[j*32+:32]; sbb[b_waddr[j*3+:3]] = 0;
        end
      if (b_rsv_en && b_rsv_addr != 0) sbb[b_rsv_addr] = 1;
      if (b_clr_req) begin b_left = 7; b_ptr = 1; end
    end
  endfunction

  function automatic logic [31:0] exp_rd_a(input logic [3:0] ad);
    logic [31:0] v;
    if (rst) return '0;
    v = ma[ad];
    if (a_left == 0)
      for (int j = 0; j < 2; j++)
        if (a_wen[j] && a_waddr[j*4+:4] != 0 && a_waddr[j*4+:4] == ad) v = a_wdata[j*32+:32];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd_b(input logic [2:0] ad);
    if (rst) return '0;
    return mb[ad];
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_raddr = '0; a_wen = '0; a_waddr = '0; a_wdata = '0; a_rsv_en = 0; a_rsv_addr = '0; a_clr_req = 0;
    b_raddr = '0; b_wen = '0; b_waddr = '0; b_wdata = '0; b_rsv_en = 0; b_rsv_addr = '0; b_clr_req = 0;
  endtask

  task automatic test_reset();
    idle();
    a_wen = 2'b01; a_waddr = 8'h05; a_wdata = 64'h1234; a_raddr = 8'h55;
    b_wen = 2'b01; b_waddr = 6'o05; b_wdata = 64'h1234; b_raddr = 6'o55;
    rst = 1; reset_model(); #1;
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (a_rdata !== '0 || a_pend !== '0 || a_busy !== 0 || a_done !== 0) begin
        errs++; $display("FAIL reset_a%0d rdata=%h pend=%b busy=%b done=%b exp all 0", n, a_rdata, a_pend, a_busy, a_done);
      end
      checks++;
      if (b_rdata !== '0 || b_pend !== '0 || b_busy !== 0 || b_done !== 0) begin
        errs++; $display("FAIL reset_b%0d rdata=%h pend=%b busy=%b done=%b exp all 0", n, b_rdata, b_pend, b_busy, b_done);
      end
      tick();
    end
    idle(); rst = 0; tick();
  endtask

  task automatic test_write_read();
    idle(); a_wen = 2'b01; a_waddr[3:0] = 4'd5; a_wdata[31:0] = 32'hDEADBEEF; tick();
    idle(); a_raddr[3:0] = 4'd5; #1;
    checks++;
    if (a_rdata[31:0] !== 32'hDEADBEEF) begin
      errs++; $display("FAIL wr_x5 got %h exp deadbeef", a_rdata[31:0]);
    end
    a_wen = 2'b01; a_waddr[3:0] = 4'd0; a_wdata[31:0] = 32'h1; a_raddr[3:0] = 4'd0; tick();
    idle(); #1;
    checks++;
    if (a_rdata[31:0] !== 32'h0) begin
      errs++; $display("FAIL wr_x0 got %h exp 0", a_rdata[31:0]);
    end
  endtask

  task automatic test_multi_write();
    idle();
    a_wen = 2'b11; a_waddr = {4'd7, 4'd7}; a_wdata = {32'h22, 32'h11};
    b_wen = 2'b11; b_waddr = {3'd7, 3'd7}; b_wdata = {32'h22, 32'h11};
    tick(); idle();
    a_raddr = {4'd7, 4'd7}; b_raddr = {3'd7, 3'd7}; #1;
    checks++;
    if (a_rdata !== {32'h22, 32'h22}) begin
      errs++; $display("FAIL multi_wr_a got %h exp 22 on both ports", a_rdata);
    end
    checks++;
    if (b_rdata !== {32'h22, 32'h22}) begin
      errs++; $display("FAIL multi_wr_b got %h exp 22 on both ports", b_rdata);
    end
  endtask

  task automatic test_bypass();
    idle(); b_wen = 2'b01; b_waddr[2:0] = 3'd3; b_wdata[31:0] = 32'h1234; tick();
    idle();
    a_wen = 2'b01; a_waddr[3:0] = 4'd3; a_wdata[31:0] = 32'hA5A5A5A5; a_raddr[3:0] = 4'd3;
    b_wen = 2'b01; b_waddr[2:0] = 3'd3; b_wdata[31:0] = 32'hA5A5A5A5; b_raddr[2:0] = 3'd3;
    #1;
    checks++;
    if (a_rdata[31:0] !== 32'hA5A5A5A5) begin
      errs++; $display("FAIL bypass_on got %h exp a5a5a5a5", a_rdata[31:0]);
    end
    checks++;
    if (b_rdata[31:0] !== 32'h1234) begin
      errs++; $display("FAIL bypass_off got %h exp 00001234", b_rdata[31:0]);
    end
    a_wen = 2'b11; a_waddr = {4'd3, 4'd3}; a_wdata = {32'hBBBB, 32'hAAAA}; #1;
    checks++;
    if (a_rdata[31:0] !== 32'hBBBB) begin
      errs++; $display("FAIL bypass_prio got %h exp 0000bbbb", a_rdata[31:0]);
    end
    tick(); idle(); a_raddr[3:0] = 4'd3; b_raddr[2:0] = 3'd3; #1;
    checks++;
    if (a_rdata[31:0] !== 32'hBBBB || b_rdata[31:0] !== 32'hA5A5A5A5) begin
      errs++; $display("FAIL bypass_commit a=%h exp bbbb b=%h exp a5a5a5a5", a_rdata[31:0], b_rdata[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    idle(); a_rsv_en = 1; a_rsv_addr = 4'd9; tick();
    idle(); a_raddr = {4'd9, 4'd9}; #1;
    checks++;
    if (a_pend !== 2'b11) begin errs++; $display("FAIL rsv_set got %b exp 11", a_pend); end
    a_wen = 2'b01; a_waddr[3:0] = 4'd9; a_wdata[31:0] = 32'h99; #1;
    checks++;
    if (a_pend !== 2'b11) begin errs++; $display("FAIL rsv_nobypass got %b exp 11", a_pend); end
    tick(); idle(); a_raddr = {4'd9, 4'd9}; #1;
    checks++;
    if (a_pend !== 2'b00) begin errs++; $display("FAIL rsv_wr_clr got %b exp 00", a_pend); end
    a_rsv_en = 1; a_rsv_addr = 4'd9; a_wen = 2'b01; a_waddr[3:0] = 4'd9; a_wdata[31:0] = 32'h77;
    tick(); idle(); a_raddr = {4'd9, 4'd9}; #1;
    checks++;
    if (a_pend !== 2'b11 || a_rdata[31:0] !== 32'h77) begin
      errs++; $display("FAIL rsv_and_wr pend=%b exp 11 data=%h exp 77", a_pend, a_rdata[31:0]);
    end
    a_rsv_en = 1; a_rsv_addr = 4'd0; tick(); idle(); #1;
    checks++;
    if (a_pend !== 2'b00) begin errs++; $display("FAIL rsv_x0 got %b exp 00", a_pend); end
  endtask

  task automatic test_clear();
    int n;
    int dn;
    idle();
    for (int r = 1; r < 8; r++) begin
      b_wen = 2'b01; b_waddr[2:0] = 3'(r); b_wdata[31:0] = 32'h100 + 32'(r);
      b_rsv_en = 1; b_rsv_addr = 3'(8 - r); tick();
    end
    idle(); b_raddr = {3'd1, 3'd7}; #1;
    checks++;
    if (b_rdata !== {32'h101, 32'h107}) begin
      errs++; $display("FAIL clr_fill got %h exp 00000101_00000107", b_rdata);
    end
    b_clr_req = 1; tick();
    n = 0; dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (b_done) dn++;
      if (!b_busy) break;
      n++;
      b_wen = 2'b11; b_waddr = {3'($urandom_range(1, 7)), 3'($urandom_range(1, 7))};
      b_wdata = {$urandom(), $urandom()}; b_rsv_en = 1; b_rsv_addr = 3'($urandom_range(1, 7));
      tick();
    end
    idle();
    checks++;
    if (n != 7) begin errs++; $display("FAIL clr_busy_len got %0d exp 7", n); end
    checks++;
    if (dn != 1) begin errs++; $display("FAIL clr_done_seen got %0d exp 1", dn); end
    tick();
    checks++;
    if (b_done !== 0 || b_busy !== 0) begin
      errs++; $display("FAIL clr_after done=%b busy=%b exp 0 0", b_done, b_busy);
    end
    for (int r = 0; r < 8; r++) begin
      b_raddr = {3'(r), 3'(r)}; #1;
      checks++;
      if (b_rdata !== '0 || b_pend !== '0) begin
        errs++; $display("FAIL clr_x%0d data=%h pend=%b exp 0", r, b_rdata, b_pend);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    idle();
    for (int r = 1; r < 8; r++) begin
      b_wen = 2'b01; b_waddr[2:0] = 3'(r); b_wdata[31:0] = 32'h200 + 32'(r); tick();
    end
    idle(); b_clr_req = 1; tick();
    b_clr_req = 0; tick(); tick();
    b_raddr = {3'd6, 3'd7}; b_rsv_en = 1; b_rsv_addr = 3'd5;
    rst = 1; reset_model(); #1;
    checks++;
    if (b_rdata !== '0 || b_pend !== '0 || b_busy !== 0 || b_done !== 0) begin
      errs++; $display("FAIL rst_mid rdata=%h pend=%b busy=%b done=%b exp all 0", b_rdata, b_pend, b_busy, b_done);
    end
    tick(); idle(); rst = 0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      b_raddr = {3'd6, 3'd7};
      tick();
      if (b_done !== 0 || b_busy !== 0 || b_rdata !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errs++; $display("FAIL rst_mid_after got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_wen = 2'($urandom); a_waddr = 8'($urandom); a_wdata = {$urandom(), $urandom()};
      a_raddr = 8'($urandom); a_rsv_en = 1'($urandom); a_rsv_addr = 4'($urandom);
      a_clr_req = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 2) == 0) a_raddr[3:0] = a_waddr[3:0];
      if ($urandom_range(0, 2) == 0) a_raddr[7:4] = a_waddr[7:4];
      b_wen = 2'($urandom); b_waddr = 6'($urandom); b_wdata = {$urandom(), $urandom()};
      b_raddr = 6'($urandom); b_rsv_en = 1'($urandom); b_rsv_addr = 3'($urandom);
      b_clr_req = ($urandom_range(0, 63) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_rdata[k*32+:32] !== exp_rd_a(a_raddr[k*4+:4])) begin
          errs++; $display("FAIL rand_a_rd%0d cyc %0d got %h exp %h", k, c, a_rdata[k*32+:32], exp_rd_a(a_raddr[k*4+:4]));
        end
        checks++;
        if (b_rdata[k*32+:32] !== exp_rd_b(b_raddr[k*3+:3])) begin
          errs++; $display("FAIL rand_b_rd%0d cyc %0d got %h exp %h", k, c, b_rdata[k*32+:32], exp_rd_b(b_raddr[k*3+:3]));
        end
      end
      checks++;
      if (a_pend !== {sba[a_raddr[7:4]], sba[a_raddr[3:0]]} || a_busy !== (a_left > 0) || a_done !== a_done_exp) begin
        errs++; $display("FAIL rand_a_ctl cyc %0d pend=%b busy=%b done=%b exp %b %b %b", c, a_pend, a_busy, a_done,
                         {sba[a_raddr[7:4]], sba[a_raddr[3:0]]}, (a_left > 0), a_done_exp);
      end
      checks++;
      if (b_pend !== {sbb[b_raddr[5:3]], sbb[b_raddr[2:0]]} || b_busy !== (b_left > 0) || b_done !== b_done_exp) begin
        errs++; $display("FAIL rand_b_ctl cyc %0d pend=%b busy=%b done=%b exp %b %b %b", c, b_pend, b_busy, b_done,
                         {sbb[b_raddr[5:3]], sbb[b_raddr[2:0]]}, (b_left > 0), b_done_exp);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset_model();
    idle();
    #2;
    test_reset();
    test_write_read();
    test_multi_write();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rf_mp.md
RF_MP -- requirements
Module: rf_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, power of 2, >=4; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 2: independent asynchronous read ports.
REQ-004 SHALL have parameter NUM_WR, default 1: synchronous write ports, 1..4.
REQ-005 SHALL have parameter BYPASS_EN, default 0: 1 forwards same-cycle write data to the read ports.
REQ-006 SHALL have port i_clk  in  1  global clock; one clock domain.
REQ-007 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports i_raddr  in  NUM_RD*AW, and o_rdata  out  NUM_RD*DATA_W: packed read addresses and data, port k in slice k.
REQ-009 SHALL have ports i_wen  in  NUM_WR; i_waddr  in  NUM_WR*AW; i_wdata  in  NUM_WR*DATA_W: packed write enables, addresses, data.
REQ-010 SHALL have ports i_rsv_en  in  1, and i_rsv_addr  in  AW: reserve (mark pending) a destination register.
REQ-011 SHALL have port o_pending  out  NUM_RD: bit k high when register i_raddr[k] is reserved and not yet written.
REQ-012 SHALL have ports i_clr_req  in  1; o_clr_busy  out  1; o_clr_done  out  1: bulk-clear request, busy level, one-cycle done pulse.

Function
REQ-013 Register 0 SHALL read as zero, ignore writes, never be pending.
REQ-014 Writes SHALL commit at the rising edge when i_wen[j]=1 and the address is nonzero; data visible on reads the cycle after.
REQ-015 Same-edge writes from several ports to one address: the highest-index port SHALL win.
REQ-016 With BYPASS_EN=1, read port k SHALL return the winning same-cycle i_wdata when its address matches an enabled nonzero write; with BYPASS_EN=0, stored value only.
REQ-017 o_pending SHALL be combinational from the scoreboard; no bypass is applied to pending bits.
REQ-018 i_rsv_en with nonzero i_rsv_addr SHALL set that scoreboard bit at the edge; a committed write SHALL clear its address bit.
REQ-019 Reserve and write to the same address at the same edge: set SHALL win (bit ends 1, data still written).
REQ-020 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on i_clr_req; i_clr_req ignored in CLEAR.
REQ-021 In CLEAR, an AW-bit index SHALL start at 1 and zero one register plus its scoreboard bit per cycle, ending at NUM_REGS-1; o_clr_busy high for exactly NUM_REGS-1 cycles.
REQ-022 o_clr_done SHALL pulse one cycle on the cycle after the last clear write, FSM back in IDLE.
REQ-023 During CLEAR, write ports and reservations SHALL be ignored; reads return current (partially cleared) contents; bypass disabled.
REQ-024 Index wrap: increment from NUM_REGS-1 SHALL not occur; CLEAR exits instead.

Reset
REQ-025 i_rst SHALL asynchronously zero all registers and scoreboard bits, force IDLE, index 1.
REQ-026 During and after reset: o_rdata=0, o_pending=0, o_clr_busy=0, o_clr_done=0.
REQ-027 Reset mid-CLEAR SHALL abort immediately without a done pulse.

Structure
REQ-028 Clear-FSM state encodings and AW derivation SHALL live in shared package rf_pkg.
REQ-029 Scoreboard SHALL be a sub-module rf_scoreboard (set/clear/flush, NUM_RD lookup ports).

Verification
REQ-030 Default params: write x5=0xDEADBEEF, next cycle read port0 x5 -> 0xDEADBEEF; write x0=0x1 -> reads 0.
REQ-031 NUM_WR=2: port0 x7=0x11, port1 x7=0x22 same edge -> x7=0x22.
REQ-032 BYPASS_EN=1: write x3=0xA5A5A5A5, read x3 same cycle -> 0xA5A5A5A5; BYPASS_EN=0 -> old value.
REQ-033 Reserve x9, read x9 -> o_pending=1; write x9 -> pending 0; reserve+write x9 same edge -> pending 1.
REQ-034 NUM_REGS=8 fill x1..x7, pulse i_clr_req -> busy 7 cycles, done pulse, all reads 0; writes during busy dropped.
REQ-035 Assert i_rst at 3rd CLEAR cycle -> all outputs 0, no done pulse, FSM IDLE.
